// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared width codes, FSM state encoding and byte-lane offset
//            helper for the data-memory load/store unit.
// Revision : 1.0
// ============================================================================
package dmem_pkg;

    // RISC-V load/store width codes (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // FSM state encoding
    localparam int         STATE_W  = 2;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RD    = 2'd1;
    localparam logic [1:0] ST_WR    = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Bit position of the least-significant bit of the addressed byte/half.
    // Big endian: byte k sits at [31-8k -: 8], half at offset 0 is [31:16].
    function automatic logic [4:0] lane_shift(
        input logic       big_endian,
        input logic       is_half,
        input logic [1:0] offset
    );
        logic [1:0] lane_idx;
        if (big_endian) begin
            lane_idx = is_half ? (2'd2 - offset) : (2'd3 - offset);
        end else begin
            lane_idx = offset;
        end
        return {lane_idx, 3'b000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane
// Purpose  : Combinational lane logic: extracts and extends load data from a
//            memory word, and merges store data into a memory word.
// Revision : 1.0
// ============================================================================
module dmem_lane
    import dmem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);

    logic [4:0]  w_shift;
    logic [31:0] w_lane;
    logic [31:0] w_mask;
    logic [31:0] w_ins;

    assign w_shift = lane_shift(BIG_ENDIAN, i_funct3[0], i_offset);
    assign w_lane  = i_word >> w_shift;

    // Load: pick the addressed lane and sign- or zero-extend it
    always_comb begin
        o_load_data = '0;
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
            F3_H:    o_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
            F3_W:    o_load_data = i_word;
            F3_BU:   o_load_data = {24'b0, w_lane[7:0]};
            F3_HU:   o_load_data = {16'b0, w_lane[15:0]};
            default: o_load_data = '0;
        endcase
    end

    // Store: replace the addressed lane of the old word; a word store replaces all
    always_comb begin
        w_mask       = '0;
        w_ins        = '0;
        o_merge_data = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                w_mask       = 32'h0000_00FF << w_shift;
                w_ins        = {24'b0, i_wdata[7:0]} << w_shift;
                o_merge_data = (i_word & ~w_mask) | w_ins;
            end
            2'b01: begin
                w_mask       = 32'h0000_FFFF << w_shift;
                w_ins        = {16'b0, i_wdata[15:0]} << w_shift;
                o_merge_data = (i_word & ~w_mask) | w_ins;
            end
            default: o_merge_data = i_wdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lsu
// Purpose  : Load/store initiator for a word-only data memory. Byte/half
//            stores are performed as read-modify-write; responses are a
//            single-cycle pulse with extended load data or an error flag.
// Revision : 1.0
// ============================================================================
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int WORD_SIZE  = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 resp_valid,
    output logic                 resp_err,
    output logic [WORD_SIZE-1:0] resp_rdata,
    output logic                 r_w,
    output logic [31:0]          mem_addr,
    output logic [WORD_SIZE-1:0] mem_data,
    input  logic [WORD_SIZE-1:0] mem_out
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;

    logic        r_we;
    logic        r_err;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [31:0] r_wdata;
    logic [31:0] r_data;
    logic [31:0] r_mem_addr;

    logic        w_accept;
    logic        w_legal;
    logic        w_misaligned;
    logic        w_err;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    assign w_accept = req_valid && (r_state == ST_IDLE);

    // Classify the incoming request: illegal width code or misaligned address
    always_comb begin
        w_legal      = 1'b0;
        w_misaligned = 1'b0;
        case (req_funct3)
            F3_B:         w_legal = 1'b1;
            F3_H:         w_legal = 1'b1;
            F3_W:         w_legal = 1'b1;
            F3_BU, F3_HU: w_legal = !req_we;
            default:      w_legal = 1'b0;
        endcase
        if ((req_funct3 == F3_H) || (req_funct3 == F3_HU)) begin
            w_misaligned = req_addr[0];
        end else if (req_funct3 == F3_W) begin
            w_misaligned = |req_addr[1:0];
        end
        w_err = !w_legal || w_misaligned;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; sub-word stores go through RD to fetch the old word
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_err) begin
                        w_next = ST_RESP;
                    end else if (req_we && (req_funct3 == F3_W)) begin
                        w_next = ST_WR;
                    end else begin
                        w_next = ST_RD;
                    end
                end
            end
            ST_RD:   w_next = r_we ? ST_WR : ST_RESP;
            ST_WR:   w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Request capture at acceptance and memory word capture at the end of RD
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_funct3   <= '0;
            r_off      <= '0;
            r_wdata    <= '0;
            r_data     <= '0;
            r_mem_addr <= '0;
        end else begin
            if (w_accept) begin
                r_we     <= req_we;
                r_err    <= w_err;
                r_funct3 <= req_funct3;
                r_off    <= req_addr[1:0];
                r_wdata  <= req_wdata;
                // Erroring requests never address memory, so the index is left alone
                if (!w_err) begin
                    r_mem_addr <= {2'b00, req_addr[31:2]};
                end
            end
            if (r_state == ST_RD) begin
                r_data <= mem_out;
            end
        end
    end

    dmem_lane #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane (
        .i_funct3     (r_funct3),
        .i_offset     (r_off),
        .i_word       (r_data),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load),
        .o_merge_data (w_merge)
    );

    assign req_ready  = (r_state == ST_IDLE);
    assign r_w        = (r_state == ST_WR);
    assign mem_addr   = r_mem_addr;
    assign mem_data   = r_w ? w_merge : '0;
    assign resp_valid = (r_state == ST_RESP);
    assign resp_err   = resp_valid && r_err;
    assign resp_rdata = (resp_valid && !r_err && !r_we) ? w_load : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_lsu
// Purpose  : Self-checking bench for dmem_lsu with a byte-level behavioural
//            model, a per-cycle compare process and directed vectors.
// Revision : 1.0
// ============================================================================
module tb_dmem_lsu;

    localparam bit BIG = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        r_w;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] mem_out;

    dmem_lsu #(
        .WORD_SIZE  (32),
        .BIG_ENDIAN (BIG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .r_w        (r_w),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_out    (mem_out)
    );

    always #5 clk = ~clk;

    // Memory the DUT talks to; the bench preloads it through the poke port
    logic [31:0] mem [0:255];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_idx;
    logic [31:0] poke_val;
    assign mem_out = mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (poke_en) mem[poke_idx] <= poke_val;
        else if (r_w) mem[mem_addr[7:0]] <= mem_data;
    end

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    int checks = 0;
    int errors = 0;
    int wr_pulses = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    logic [31:0] mdl_mem [0:255];

    typedef struct { int cyc; bit err; logic [31:0] rd; } resp_t;
    typedef struct { int cyc; logic [31:0] a; logic [31:0] d; } wr_t;
    resp_t rq[$];
    wr_t   wq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model working on individual bytes of the addressed word
    function automatic void model_op(input bit we, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wd,
                                     output bit err, output logic [31:0] rd,
                                     output int lat, output logic [31:0] nw);
        int k, sz, idx;
        logic [7:0]  b [4];
        logic [15:0] h;
        logic [31:0] w;
        bit legal;
        k   = int'(addr[1:0]);
        idx = int'(addr[9:2]);
        w   = mdl_mem[idx];
        case (f3)
            3'b000, 3'b100: sz = 1;
            3'b001, 3'b101: sz = 2;
            3'b010:         sz = 4;
            default:        sz = 0;
        endcase
        legal = we ? (f3 <= 3'b010) : (sz != 0);
        err   = !legal || ((sz != 0) && ((k % sz) != 0));
        for (int i = 0; i < 4; i++) b[i] = 8'(w >> (BIG ? 8 * (3 - i) : 8 * i));
        rd  = '0;
        nw  = w;
        lat = 1;
        if (err) return;
        if (!we) begin
            lat = 2;
            if (sz == 4) begin
                rd = w;
            end else if (sz == 2) begin
                h  = BIG ? {b[k], b[k+1]} : {b[k+1], b[k]};
                rd = (f3 == 3'b001 && h[15]) ? {16'hFFFF, h} : {16'h0000, h};
            end else begin
                rd = (f3 == 3'b000 && b[k][7]) ? {24'hFFFFFF, b[k]} : {24'h0, b[k]};
            end
        end else begin
            lat = (sz == 4) ? 2 : 3;
            if (sz == 4) begin
                nw = wd;
            end else begin
                if (sz == 1) begin
                    b[k] = wd[7:0];
                end else if (BIG) begin
                    b[k] = wd[15:8]; b[k+1] = wd[7:0];
                end else begin
                    b[k] = wd[7:0];  b[k+1] = wd[15:8];
                end
                nw = '0;
                for (int i = 0; i < 4; i++) nw = nw | (32'(b[i]) << (BIG ? 8 * (3 - i) : 8 * i));
            end
        end
    endfunction

    // Per-cycle comparison of response and memory-write outputs against the model
    always @(negedge clk) begin
        bit ev;
        bit ew;
        if (!reset) begin
            ev = (rq.size() > 0) && (rq[0].cyc == edges);
            chk("resp_valid", 32'(resp_valid), 32'(ev));
            if (ev) begin
                chk("resp_err", 32'(resp_err), 32'(rq[0].err));
                chk("resp_rdata", resp_rdata, rq[0].rd);
            end
            if (resp_valid) begin
                last_rdata = resp_rdata;
                last_err   = resp_err;
            end
            if ((rq.size() > 0) && (rq[0].cyc <= edges)) void'(rq.pop_front());
            ew = (wq.size() > 0) && (wq[0].cyc == edges);
            chk("r_w", 32'(r_w), 32'(ew));
            if (ew) begin
                chk("mem_addr", mem_addr, wq[0].a);
                chk("mem_data", mem_data, wq[0].d);
            end
            if ((wq.size() > 0) && (wq[0].cyc <= edges)) void'(wq.pop_front());
            if (r_w) wr_pulses++;
        end
    end

    task automatic poke(input int idx, input logic [31:0] val);
        poke_idx = 8'(idx);
        poke_val = val;
        poke_en  = 1'b1;
        mdl_mem[idx] = val;
        @(negedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit track, output int acc);
        int n;
        bit e;
        logic [31:0] rd, nw;
        int lat;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready 0 expected 1");
            acc = -1;
            return;
        end
        acc = edges;
        if (track) begin
            model_op(we, f3, addr, wd, e, rd, lat, nw);
            rq.push_back('{acc + lat, e, rd});
            if (we && !e) begin
                wq.push_back('{acc + lat - 1, {2'b00, addr[31:2]}, nw});
                mdl_mem[int'(addr[9:2])] = nw;
            end
        end
        @(negedge clk); #1;
    endtask

    task automatic drain();
        int n;
        req_valid = 1'b0;
        n = 0;
        while ((rq.size() > 0 || wq.size() > 0) && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (rq.size() > 0 || wq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending %0d expected 0", rq.size() + wq.size());
            rq.delete();
            wq.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, wp;
        for (int i = 0; i < 256; i++) mdl_mem[i] = '0;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_r_w", 32'(r_w), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_data", mem_data, 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk); #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        // Loads
        poke(4, 32'h1122_3344);
        issue(1'b0, 3'b000, 32'h11, '0, 1'b1, a1); drain();
        chk("lb_0x11", last_rdata, 32'h0000_0022);
        poke(4, 32'h1122_A344);
        issue(1'b0, 3'b001, 32'h12, '0, 1'b1, a1); drain();
        chk("lh_0x12", last_rdata, 32'hFFFF_A344);
        issue(1'b0, 3'b101, 32'h12, '0, 1'b1, a1); drain();
        chk("lhu_0x12", last_rdata, 32'h0000_A344);

        // Byte store as read-modify-write, then read back
        poke(4, 32'h1122_3344);
        wp = wr_pulses;
        issue(1'b1, 3'b000, 32'h12, 32'h0000_00AB, 1'b1, a1); drain();
        chk("sb_one_write", 32'(wr_pulses - wp), 32'd1);
        chk("sb_mem4", mem[4], 32'h1122_AB44);
        chk("sb_rdata", last_rdata, 32'd0);
        issue(1'b0, 3'b010, 32'h10, '0, 1'b1, a1); drain();
        chk("lw_0x10", last_rdata, 32'h1122_AB44);

        // Errors: misaligned and illegal width codes
        wp = wr_pulses;
        issue(1'b0, 3'b010, 32'h12, '0, 1'b1, a1); drain();
        chk("lw_mis_err", 32'(last_err), 32'd1);
        issue(1'b1, 3'b001, 32'h13, 32'h1234, 1'b1, a1); drain();
        chk("sh_mis_err", 32'(last_err), 32'd1);
        issue(1'b0, 3'b011, 32'h10, '0, 1'b1, a1); drain();
        issue(1'b1, 3'b100, 32'h10, 32'h55, 1'b1, a1); drain();
        chk("err_no_write", 32'(wr_pulses - wp), 32'd0);
        chk("err_mem4", mem[4], 32'h1122_AB44);

        // Half store at offset 0 and further lane extraction
        issue(1'b1, 3'b001, 32'h10, 32'h0000_8001, 1'b1, a1); drain();
        chk("sh_mem4", mem[4], 32'h8001_AB44);
        issue(1'b0, 3'b001, 32'h10, '0, 1'b1, a1); drain();
        chk("lh_0x10", last_rdata, 32'hFFFF_8001);
        issue(1'b0, 3'b100, 32'h13, '0, 1'b1, a1); drain();
        chk("lbu_0x13", last_rdata, 32'h0000_0044);
        issue(1'b0, 3'b000, 32'h12, '0, 1'b1, a1); drain();
        chk("lb_0x12", last_rdata, 32'hFFFF_FFAB);

        // Reset during the RD cycle of a half store
        wp = wr_pulses;
        issue(1'b1, 3'b001, 32'h10, 32'h0000_BEEF, 1'b0, a1);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_r_w", 32'(r_w), 32'd0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        repeat (4) @(negedge clk);
        #1;
        chk("mid_rst_no_write", 32'(wr_pulses - wp), 32'd0);
        chk("mid_rst_mem4", mem[4], 32'h8001_AB44);

        // Back-to-back with req_valid held high
        issue(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 1'b1, a1);
        issue(1'b0, 3'b010, 32'h20, '0, 1'b1, a2);
        chk("b2b_accept", 32'(a2 - a1), 32'd3);
        drain();
        chk("b2b_lw", last_rdata, 32'hDEAD_BEEF);
        chk("b2b_mem8", mem[8], 32'hDEAD_BEEF);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store initiator that sits between the core's memory stage and the word-only, big-endian data memory.
- Accepts byte, halfword and word loads and stores from the core over a valid/ready request channel.
- Translates byte addresses to word indices and sign- or zero-extends load data.
- Sub-word stores are done as read-modify-write (RMW), because the memory has no byte enables.
- Returns a one-cycle response pulse carrying load data or an error flag.

Parameters:
- WordSize, 32, data width; only 32 is supported.
- BigEndian, 1, 1 = byte offset 0 is bits [31:24]; 0 = byte offset 0 is bits [7:0].

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  one-cycle pulse when an operation completes.
- resp_err  output  1  qualifies resp_valid; set for misaligned or illegal funct3.
- resp_rdata  output  32  extended load data, valid with resp_valid; 0 for stores and errors.
- r_w  output  1  memory write strobe.
- mem_addr  output  32  memory word index = {2'b00, addr[31:2]}.
- mem_data  output  32  memory write data.
- mem_out  input  32  combinational memory read data for the current mem_addr.

Behaviour:
- Reset: all outputs are registered or decoded from state, and go to state IDLE.
  - Reset values: r_w=0, mem_addr=0, mem_data=0, resp_valid=0, resp_err=0, resp_rdata=0.
  - req_ready=1 from the first cycle after reset deasserts.
- Reset mid-operation: a reset sampled in any state returns to IDLE with r_w=0; no write and no response is produced.
- States: IDLE, RD, WR, RESP.
- On acceptance, latch we, funct3, addr and wdata, then classify:
  - Misaligned (H with addr[0]=1, W with addr[1:0]!=0), illegal load funct3 (011, 110, 111), or illegal store funct3 (anything but 000/001/010) -> RESP with err=1. Memory is never touched and r_w stays 0.
  - Load -> RD.
  - Store word -> WR.
  - Store byte/half -> RD.
- RD (1 cycle): mem_addr holds the word index and r_w=0.
  - mem_out is captured into a data register at the end of the cycle.
  - Next state: RESP for loads, WR for RMW stores.
- WR (1 cycle): r_w=1, mem_addr = word index.
  - mem_data = wdata for SW.
  - For SB/SH, mem_data = the captured word with the addressed byte/half replaced by wdata[7:0]/[15:0].
  - Lane choice follows BigEndian. Big endian: byte offset k occupies bits [31-8k -: 8]; halfword offset 0 = [31:16], offset 2 = [15:0].
  - Next state: RESP.
- RESP (1 cycle): resp_valid=1, then IDLE.
  - Loads: the lane is extracted from the captured word. B/H are sign-extended from bit 7/15; BU/HU are zero-extended.
- Latency from the acceptance edge to resp_valid:
  - Load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- r_w is never high outside WR.
- mem_addr holds its last value in IDLE/RESP.
- Back-to-back: a new request can be accepted in the cycle immediately after RESP (IDLE). There is no overlap and no queuing.
- The core must hold its request fields stable only until acceptance; the block does not depend on them afterwards.
- Address bits [31:2] pass through unchanged. Wrap-around or out-of-range indices are the memory's concern.

Decomposition:
- Shared package dmem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state encoding IDLE/RD/WR/RESP;
  - the byte-lane offset function.
- One sub-module, dmem_lane (purely combinational), covering:
  - extract + extend for loads;
  - merge for stores.
  - It is instantiated once and shared by the RD/WR/RESP datapath.

Test Plan:
- Word index 4 = 0x11223344; LB at 0x11 -> resp_valid 2 cycles after acceptance, rdata=0x00000022, err=0, r_w stays 0.
- Word 4 = 0x1122A344; LH at 0x12 -> rdata=0xFFFFA344; LHU at 0x12 -> 0x0000A344.
- Word 4 = 0x11223344; SB 0x000000AB at 0x12:
  - RD then WR, with exactly one r_w=1 cycle at mem_addr=4 and mem_data=0x1122AB44;
  - resp_valid 3 cycles after acceptance with rdata=0;
  - a follow-up LW at 0x10 returns 0x1122AB44.
- LW at 0x12 and SH at 0x13 -> resp_err=1 one cycle after acceptance, rdata=0, no r_w pulse, memory unchanged.
- SH 0xBEEF at 0x10, with reset asserted on the edge ending RD -> state IDLE, r_w never 1, word 4 unchanged, no resp_valid.
- Back-to-back SW 0xDEADBEEF at 0x20 then LW at 0x20, with req_valid held high -> second request accepted in the cycle after the first RESP, returns 0xDEADBEEF.
